// File: rtl/bcd_pkg.sv
// Shared types and helpers for the arbitrated binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] BCD_NINE = 4'h9;

   // Decimal digits needed to hold the largest bin_width-bit value.
   function automatic int nibble_count(input int bin_width);
      longint v;
      int     n;
      v = (longint'(1) << bin_width) - 1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 10) begin
            v = v / 10;
            n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Serial double-dabble engine: load, BIN_WIDTH add-3/shift cycles, one-cycle done pulse.
module bcd_dabble_core #(
   parameter int BIN_WIDTH = 7,
   parameter int NIB       = 3
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   input  logic                 load,
   input  logic [BIN_WIDTH-1:0] bin,
   output logic                 o_Last,
   output logic                 o_Done,
   output logic [4*NIB-1:0]     o_Result
);

   localparam int CW = $clog2(BIN_WIDTH + 1);

   logic [CW-1:0]        count;
   logic [BIN_WIDTH-1:0] shreg;
   logic [4*NIB-1:0]     acc;
   logic [4*NIB-1:0]     adj;

   always_comb begin
      adj = acc;
      for (int i = 0; i < NIB; i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         count  <= '0;
         o_Done <= 1'b0;
      end else begin
         o_Done <= (count == CW'(1));
         if (load)              count <= CW'(BIN_WIDTH);
         else if (count != '0) count <= count - CW'(1);
      end
   end

   // Datapath registers carry no reset; count gates every use of them.
   always_ff @(posedge i_Clk) begin
      if (load) begin
         shreg <= bin;
         acc   <= '0;
      end else if (count != '0) begin
         {acc, shreg} <= {adj, shreg} << 1;
      end
   end

   assign o_Last   = (count == CW'(1));
   assign o_Result = acc;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one serial BCD engine between two four-phase requesters.
module bcd_convert_arbiter
   import bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 7,
   parameter int DIGITS    = 2
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   input  logic                  i_Req_0,
   input  logic [BIN_WIDTH-1:0]  i_Binary_0,
   output logic                  o_Ack_0,
   output logic [4*DIGITS-1:0]   o_BCD_0,
   output logic                  o_Ovf_0,
   input  logic                  i_Req_1,
   input  logic [BIN_WIDTH-1:0]  i_Binary_1,
   output logic                  o_Ack_1,
   output logic [4*DIGITS-1:0]   o_BCD_1,
   output logic                  o_Ovf_1,
   output logic                  o_Busy
);

   localparam int NEED = nibble_count(BIN_WIDTH);
   localparam int NIB  = (NEED > DIGITS + 1) ? NEED : DIGITS + 1;
   localparam int OW   = 4 * DIGITS;

   state_t               state, state_nxt;
   logic                 gnt, gnt_nxt, last_g;
   logic                 armed_0, armed_1, elig_0, elig_1;
   logic                 load, commit, core_last, core_done;
   logic [BIN_WIDTH-1:0] load_bin;
   logic [4*NIB-1:0]     raw;
   logic [OW:0]          sat;

   // Returns {ovf, bcd}; any digit beyond DIGITS forces all nines.
   function automatic logic [OW:0] saturate(input logic [4*NIB-1:0] r);
      logic [OW:0] s;
      s = '0;
      if (|r[4*NIB-1:OW]) begin
         s[OW] = 1'b1;
         for (int i = 0; i < DIGITS; i++) s[4*i +: 4] = BCD_NINE;
      end else begin
         s = {1'b0, r[OW-1:0]};
      end
      return s;
   endfunction

   assign elig_0 = i_Req_0 & armed_0;
   assign elig_1 = i_Req_1 & armed_1;

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (elig_0 || elig_1) begin
               load      = 1'b1;
               state_nxt = SHIFT;
               gnt_nxt   = (elig_0 && elig_1) ? ~last_g : elig_1;
            end
         end
         SHIFT:   if (core_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign load_bin = gnt_nxt ? i_Binary_1 : i_Binary_0;
   assign commit   = (state == DONE) && core_done;
   assign sat      = saturate(raw);
   assign o_Busy   = (state != IDLE);

   bcd_dabble_core #(.BIN_WIDTH(BIN_WIDTH), .NIB(NIB)) u_core (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .load     (load),
      .bin      (load_bin),
      .o_Last   (core_last),
      .o_Done   (core_done),
      .o_Result (raw)
   );

   // last_g resets to 1 so the first contested grant goes to requester 0.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state   <= IDLE;
         gnt     <= 1'b0;
         last_g  <= 1'b1;
         armed_0 <= 1'b1;
         armed_1 <= 1'b1;
         o_Ack_0 <= 1'b0;
         o_Ack_1 <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         o_Ack_0 <= commit & ~gnt;
         o_Ack_1 <= commit & gnt;
         if (commit) last_g <= gnt;
         if (!i_Req_0)              armed_0 <= 1'b1;
         else if (commit && !gnt)   armed_0 <= 1'b0;
         if (!i_Req_1)              armed_1 <= 1'b1;
         else if (commit && gnt)    armed_1 <= 1'b0;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         {o_Ovf_0, o_BCD_0} <= '0;
         {o_Ovf_1, o_BCD_1} <= '0;
      end else if (commit) begin
         if (gnt) {o_Ovf_1, o_BCD_1} <= sat;
         else     {o_Ovf_0, o_BCD_0} <= sat;
      end
   end

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter with hand-computed BCD results.
module tb_bcd_convert_arbiter;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_Req_0 = 1'b0, i_Req_1 = 1'b0;
   logic [6:0] i_Binary_0 = '0, i_Binary_1 = '0;
   logic       o_Ack_0, o_Ack_1, o_Ovf_0, o_Ovf_1, o_Busy;
   logic [7:0] o_BCD_0, o_BCD_1;
   logic [20:0] all_out;

   int n_checks = 0;
   int n_err    = 0;

   always #5 i_Clk = ~i_Clk;

   bcd_convert_arbiter dut (
      .i_Clk      (i_Clk),
      .i_Rst_L    (i_Rst_L),
      .i_Req_0    (i_Req_0),
      .i_Binary_0 (i_Binary_0),
      .o_Ack_0    (o_Ack_0),
      .o_BCD_0    (o_BCD_0),
      .o_Ovf_0    (o_Ovf_0),
      .i_Req_1    (i_Req_1),
      .i_Binary_1 (i_Binary_1),
      .o_Ack_1    (o_Ack_1),
      .o_BCD_1    (o_BCD_1),
      .o_Ovf_1    (o_Ovf_1),
      .o_Busy     (o_Busy)
   );

   assign all_out = {o_Ack_0, o_BCD_0, o_Ovf_0, o_Ack_1, o_BCD_1, o_Ovf_1, o_Busy};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   // Single conversion; input is scrambled after the load edge to prove it is not resampled.
   task automatic conv(input string tag, input int r, input logic [6:0] v,
                       input logic [7:0] eb, input logic eo, input bit drop);
      int c = 0;
      if (r == 0) begin i_Binary_0 = v; i_Req_0 = 1'b1; end
      else        begin i_Binary_1 = v; i_Req_1 = 1'b1; end
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (k == 1) begin
            if (r == 0) i_Binary_0 = ~v; else i_Binary_1 = ~v;
         end
         if (k == 3) check({tag, "_busy"}, 32'(o_Busy), 32'd1);
         if ((r == 0) ? o_Ack_0 : o_Ack_1) begin
            c = k;
            break;
         end
      end
      check({tag, "_lat"}, c, 9);
      check({tag, "_bcd"}, 32'((r == 0) ? o_BCD_0 : o_BCD_1), 32'(eb));
      check({tag, "_ovf"}, 32'((r == 0) ? o_Ovf_0 : o_Ovf_1), 32'(eo));
      if (drop) begin
         if (r == 0) i_Req_0 = 1'b0; else i_Req_1 = 1'b0;
      end
      tick();
      check({tag, "_pulse"}, 32'((r == 0) ? o_Ack_0 : o_Ack_1), 32'd0);
      check({tag, "_idle"}, 32'(o_Busy), 32'd0);
   endtask

   // Both requesters raised on the same cycle.
   task automatic dual(input string tag, input logic [6:0] v0, input logic [6:0] v1,
                       input logic [7:0] e0, input logic [7:0] e1, input int first_exp);
      int   first = -1;
      int   c0 = 0;
      int   c1 = 0;
      logic both = 1'b0;
      i_Binary_0 = v0; i_Binary_1 = v1;
      i_Req_0 = 1'b1;  i_Req_1 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         both |= o_Ack_0 & o_Ack_1;
         if (o_Ack_0 && c0 == 0) begin
            c0 = k;
            if (first < 0) first = 0;
            check({tag, "_bcd0"}, 32'(o_BCD_0), 32'(e0));
            check({tag, "_ovf0"}, 32'(o_Ovf_0), 32'd0);
            i_Req_0 = 1'b0;
         end
         if (o_Ack_1 && c1 == 0) begin
            c1 = k;
            if (first < 0) first = 1;
            check({tag, "_bcd1"}, 32'(o_BCD_1), 32'(e1));
            check({tag, "_ovf1"}, 32'(o_Ovf_1), 32'd0);
            i_Req_1 = 1'b0;
         end
         if (c0 != 0 && c1 != 0) break;
      end
      check({tag, "_first"}, first, first_exp);
      check({tag, "_excl"}, 32'(both), 32'd0);
      check({tag, "_lat1"}, (first_exp == 0) ? c0 : c1, 9);
      check({tag, "_lat2"}, (first_exp == 0) ? c1 : c0, 18);
      tick();
   endtask

   task automatic do_reset();
      logic seen = 1'b0;
      i_Rst_L = 1'b0;
      #1;
      check("rst_out", 32'(all_out), 32'd0);
      repeat (3) begin
         tick();
         seen |= o_Ack_0 | o_Ack_1;
      end
      check("rst_noack", 32'(seen), 32'd0);
      i_Rst_L = 1'b1;
   endtask

   initial begin
      int   n;
      logic busy_seen;

      do_reset();

      conv("c42", 0, 7'd42, 8'h42, 1'b0, 1'b1);
      check("c42_other", 32'(o_BCD_1), 32'h00);

      conv("c99", 1, 7'd99, 8'h99, 1'b0, 1'b1);
      conv("c00", 1, 7'd0,  8'h00, 1'b0, 1'b1);

      conv("c127", 0, 7'd127, 8'h99, 1'b1, 1'b1);
      conv("c05",  0, 7'd5,   8'h05, 1'b0, 1'b1);
      check("c05_other", 32'(o_BCD_1), 32'h00);

      do_reset();
      dual("simA", 7'd12, 7'd34, 8'h12, 8'h34, 0);
      conv("c60", 0, 7'd60, 8'h60, 1'b0, 1'b1);
      dual("simB", 7'd45, 7'd67, 8'h45, 8'h67, 1);

      // Request held high past its ack must not be served again.
      conv("hold", 0, 7'd3, 8'h03, 1'b0, 1'b0);
      n = 0;
      busy_seen = 1'b0;
      repeat (40) begin
         tick();
         if (o_Ack_0) n++;
         busy_seen |= o_Busy;
      end
      check("hold_noack", n, 0);
      check("hold_nobusy", 32'(busy_seen), 32'd0);
      i_Req_0 = 1'b0;
      tick();
      conv("rearm", 0, 7'd56, 8'h56, 1'b0, 1'b0);
      n = 0;
      repeat (15) begin
         tick();
         if (o_Ack_0) n++;
      end
      check("rearm_once", n, 0);
      i_Req_0 = 1'b0;
      tick();

      // Reset in the middle of a conversion of 77.
      i_Binary_0 = 7'd77;
      i_Req_0    = 1'b1;
      repeat (4) tick();
      check("mid_busy", 32'(o_Busy), 32'd1);
      i_Binary_1 = 7'd21;
      i_Req_1    = 1'b1;
      #2;
      do_reset();
      dual("post", 7'd77, 7'd21, 8'h77, 8'h21, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
